scmp_uart: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the SC/MP external bus. It replaces bit-banged serial on f0/sb.
- Sits downstream of the board-level address decode: the decode drives `sel`; the block drives `dout` into the CPU read-data mux and owns `ser_tx`/`ser_rx`.
- It provides 16x-oversampled receive into an RX FIFO, transmit from a TX FIFO, a programmable baud divisor, and status flags.

---
 rtl/scmp_uart.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_scmp_uart.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_uart.sv
// scmp_uart: 8N1 UART on the SC/MP bus with 16x RX oversampling and RX/TX FIFOs.
// Optional SCMP_UART_IRQ_EN adds control register 4 and a registered irq.
module scmp_uart #(
    parameter int CLK_HZ   = 8000000,
    parameter int BAUD     = 2400,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 4
) (
    input  logic       ram_clk,
    input  logic       rst_n,
    input  logic       sel,
    input  logic [2:0] addr,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       ser_rx,
    output logic       ser_tx,
    output logic       irq
);
    localparam int DIV_RST = CLK_HZ / (16 * BAUD);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXAW = $clog2(TX_DEPTH);
    localparam logic [15:0] DIV_INIT = 16'(DIV_RST);
    localparam logic [15:0] TICK_INIT = (DIV_RST > 1) ? 16'(DIV_RST - 1) : 16'd0;
    localparam logic [RXAW:0] RX_FULLC = (RXAW + 1)'(RX_DEPTH);
    localparam logic [TXAW:0] TX_FULLC = (TXAW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic       rd_q, wr_q, rd_pend;
    logic [2:0] rd_addr, mux_addr;
    logic       rd_start, rd_end, wr_fire;
    logic [7:0] rd_data, status;

    assign rd_start = sel & rd_q & ~rd_n;
    assign wr_fire  = sel & wr_q & ~wr_n;
    assign rd_end   = rd_pend & ~rd_q & rd_n;

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            rd_pend <= 1'b0;
            rd_addr <= 3'd0;
        end else begin
            rd_q <= rd_n;
            wr_q <= wr_n;
            if (rd_start) begin
                rd_addr <= addr;
                rd_pend <= 1'b1;
            end else if (rd_end) begin
                rd_pend <= 1'b0;
            end
        end
    end

    logic [15:0] div_q, tick_cnt;
    logic        tick;

    assign tick = (tick_cnt == 16'd0);

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= DIV_INIT;
            tick_cnt <= TICK_INIT;
        end else begin
            if (wr_fire && addr == 3'd2) div_q[7:0] <= din;
            if (wr_fire && addr == 3'd3) div_q[15:8] <= din;
            if (tick) tick_cnt <= (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
            else      tick_cnt <= tick_cnt - 16'd1;
        end
    end

    logic rx_s1, rxs;

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= ser_rx;
            rxs   <= rx_s1;
        end
    end

    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RXAW-1:0] rx_wp, rx_rp;
    logic [RXAW:0]   rx_cnt;
    logic            rx_empty, rx_full, rx_push, rx_put, rx_pop;
    logic [7:0]      rx_sh;

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == RX_FULLC);
    assign rx_put   = rx_push & ~rx_full;
    assign rx_pop   = rd_end & (rd_addr == 3'd0) & ~rx_empty;

    always_ff @(posedge ram_clk) begin
        if (rx_put) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_put) rx_wp <= rx_wp + RXAW'(1);
            if (rx_pop) rx_rp <= rx_rp + RXAW'(1);
            case ({rx_put, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + (RXAW + 1)'(1);
                2'b01:   rx_cnt <= rx_cnt - (RXAW + 1)'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TXAW-1:0] tx_wp, tx_rp;
    logic [TXAW:0]   tx_cnt;
    logic            tx_empty, tx_full, tx_put, tx_pop, txo_set;

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == TX_FULLC);
    assign tx_put   = wr_fire & (addr == 3'd0) & ~tx_full;
    assign txo_set  = wr_fire & (addr == 3'd0) & tx_full;

    always_ff @(posedge ram_clk) begin
        if (tx_put) tx_mem[tx_wp] <= din;
    end

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_put) tx_wp <= tx_wp + TXAW'(1);
            if (tx_pop) tx_rp <= tx_rp + TXAW'(1);
            case ({tx_put, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (TXAW + 1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (TXAW + 1)'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // RX: 8 ticks to mid-start, then one sample every 16 ticks
    rx_state_t rx_st, rx_st_d;
    logic [3:0] rx_tc, rx_tc_d;
    logic [2:0] rx_bc, rx_bc_d;
    logic [7:0] rx_sh_d;
    logic       frm_set;

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st <= RX_IDLE;
            rx_tc <= 4'd0;
            rx_bc <= 3'd0;
            rx_sh <= 8'd0;
        end else begin
            rx_st <= rx_st_d;
            rx_tc <= rx_tc_d;
            rx_bc <= rx_bc_d;
            rx_sh <= rx_sh_d;
        end
    end

    always_comb begin
        rx_st_d = rx_st;
        rx_tc_d = rx_tc;
        rx_bc_d = rx_bc;
        rx_sh_d = rx_sh;
        rx_push = 1'b0;
        frm_set = 1'b0;
        case (rx_st)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_st_d = RX_START;
                    rx_tc_d = 4'd0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tc == 4'd7) begin
                        rx_tc_d = 4'd0;
                        rx_bc_d = 3'd0;
                        rx_st_d = rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tc_d = rx_tc + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_tc_d = rx_tc + 4'd1;
                    if (rx_tc == 4'd15) begin
                        rx_sh_d = {rxs, rx_sh[7:1]};
                        rx_bc_d = rx_bc + 3'd1;
                        if (rx_bc == 3'd7) rx_st_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_tc_d = rx_tc + 4'd1;
                    if (rx_tc == 4'd15) begin
                        rx_push = rxs;
                        frm_set = ~rxs;
                        rx_st_d = RX_IDLE;
                    end
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // TX: stop end reloads directly so back-to-back frames have no gap
    tx_state_t tx_st, tx_st_d;
    logic [3:0] tx_tc, tx_tc_d;
    logic [2:0] tx_bc, tx_bc_d;
    logic [7:0] tx_sh, tx_sh_d;
    logic       ser_tx_d, tx_idle;

    assign tx_idle = tx_empty & (tx_st == TX_IDLE);

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st  <= TX_IDLE;
            tx_tc  <= 4'd0;
            tx_bc  <= 3'd0;
            tx_sh  <= 8'd0;
            ser_tx <= 1'b1;
        end else begin
            tx_st  <= tx_st_d;
            tx_tc  <= tx_tc_d;
            tx_bc  <= tx_bc_d;
            tx_sh  <= tx_sh_d;
            ser_tx <= ser_tx_d;
        end
    end

    always_comb begin
        tx_st_d = tx_st;
        tx_tc_d = tx_tc;
        tx_bc_d = tx_bc;
        tx_sh_d = tx_sh;
        tx_pop  = 1'b0;
        case (tx_st)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_sh_d = tx_mem[tx_rp];
                    tx_tc_d = 4'd0;
                    tx_st_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_tc_d = tx_tc + 4'd1;
                    if (tx_tc == 4'd15) begin
                        tx_bc_d = 3'd0;
                        tx_st_d = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    tx_tc_d = tx_tc + 4'd1;
                    if (tx_tc == 4'd15) begin
                        tx_sh_d = {1'b1, tx_sh[7:1]};
                        tx_bc_d = tx_bc + 3'd1;
                        if (tx_bc == 3'd7) tx_st_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    tx_tc_d = tx_tc + 4'd1;
                    if (tx_tc == 4'd15) begin
                        if (!tx_empty) begin
                            tx_pop  = 1'b1;
                            tx_sh_d = tx_mem[tx_rp];
                            tx_st_d = TX_START;
                        end else begin
                            tx_st_d = TX_IDLE;
                        end
                    end
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase
        case (tx_st_d)
            TX_START: ser_tx_d = 1'b0;
            TX_DATA:  ser_tx_d = tx_sh_d[0];
            default:  ser_tx_d = 1'b1;
        endcase
    end

    logic ovr, frm, txo, stat_clr;

    assign stat_clr = rd_end & (rd_addr == 3'd1);

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr <= 1'b0;
            frm <= 1'b0;
            txo <= 1'b0;
        end else begin
            ovr <= (rx_push & rx_full) | (ovr & ~stat_clr);
            frm <= frm_set | (frm & ~stat_clr);
            txo <= txo_set | (txo & ~stat_clr);
        end
    end

    assign status = {tx_idle, 2'b00, txo, frm, ovr, ~tx_full, ~rx_empty};

`ifdef SCMP_UART_IRQ_EN
    logic [1:0] ctrl;
    logic       irq_q;

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl  <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            if (wr_fire && addr == 3'd4) ctrl <= din[1:0];
            irq_q <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_idle);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // the address is steered straight through on read start so dout lands next cycle
    assign mux_addr = rd_start ? addr : rd_addr;

    always_comb begin
        rd_data = 8'hFF;
        case (mux_addr)
            3'd0: if (!rx_empty) rd_data = rx_mem[rx_rp];
            3'd1: rd_data = status;
            3'd2: rd_data = div_q[7:0];
            3'd3: rd_data = div_q[15:8];
`ifdef SCMP_UART_IRQ_EN
            3'd4: rd_data = {6'b000000, ctrl};
`endif
            default: rd_data = 8'hFF;
        endcase
    end

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) dout <= 8'h00;
        else        dout <= rd_data;
    end

endmodule

// File: tb/tb_scmp_uart.sv
// tb_scmp_uart: directed bus/serial stimulus with scoreboard queues
// for register reads and transmitted frames.
module tb_scmp_uart;
    logic       ram_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sel = 1'b0;
    logic [2:0] addr = 3'd0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       ser_rx = 1'b1;
    logic       ser_tx;
    logic       irq;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] rd_exp [$];
    string      rd_nm [$];
    logic [7:0] tx_exp [$];
    bit         tx_mon_en = 1'b1;
    int         rd_low = 0;
    logic [9:0] tx_fr;
    logic [7:0] e_byte;
    string      e_nm;

    always #5 ram_clk = ~ram_clk;

    scmp_uart dut (
        .ram_clk(ram_clk),
        .rst_n(rst_n),
        .sel(sel),
        .addr(addr),
        .rd_n(rd_n),
        .wr_n(wr_n),
        .din(din),
        .dout(dout),
        .ser_rx(ser_rx),
        .ser_tx(ser_tx),
        .irq(irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // read monitor: dout sampled one clock after the read strobe lands
    always @(negedge ram_clk) begin
        if (!rd_n && sel) rd_low = rd_low + 1;
        else              rd_low = 0;
        if (rd_low == 2) begin
            if (rd_exp.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h, expected no read", dout);
            end else begin
                e_byte = rd_exp.pop_front();
                e_nm = rd_nm.pop_front();
                check(e_nm, {24'd0, dout}, {24'd0, e_byte});
            end
        end
    end

    // TX monitor: 16 clocks per bit, sample at mid-bit
    initial begin
        forever begin
            @(negedge ram_clk);
            if (tx_mon_en && ser_tx === 1'b0) begin
                repeat (7) @(negedge ram_clk);
                tx_fr[0] = ser_tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (16) @(negedge ram_clk);
                    tx_fr[i] = ser_tx;
                end
                if (tx_mon_en) begin
                    if (tx_exp.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got frame %0h, expected none", tx_fr);
                    end else begin
                        e_byte = tx_exp.pop_front();
                        check("tx_frame", {22'd0, tx_fr}, {22'd0, 1'b1, e_byte, 1'b0});
                    end
                end
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge ram_clk);
        #1;
        sel = 1'b1;
        addr = a;
        din = d;
        wr_n = 1'b0;
        @(posedge ram_clk);
        #1;
        wr_n = 1'b1;
        sel = 1'b0;
        @(posedge ram_clk);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
        @(posedge ram_clk);
        #1;
        sel = 1'b1;
        addr = a;
        rd_n = 1'b0;
        rd_exp.push_back(exp);
        rd_nm.push_back(nm);
        repeat (3) @(posedge ram_clk);
        #1;
        rd_n = 1'b1;
        @(posedge ram_clk);
        #1;
        sel = 1'b0;
        @(posedge ram_clk);
    endtask

    task automatic bit_out(input logic v, input int n);
        ser_rx = v;
        repeat (n) @(posedge ram_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input int stop_len);
        @(posedge ram_clk);
        #1;
        bit_out(1'b0, 16);
        for (int i = 0; i < 8; i++) bit_out(b[i], 16);
        bit_out(stop_v, stop_len);
        ser_rx = 1'b1;
    endtask

    task automatic settle();
        repeat (2) @(posedge ram_clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge ram_clk);
        #1;
        check("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;

        rd(3'd1, 8'h82, "rst_status");
        rd(3'd2, 8'hD0, "rst_div_lo");
        rd(3'd3, 8'h00, "rst_div_hi");
`ifdef SCMP_UART_IRQ_EN
        rd(3'd4, 8'h00, "rst_ctrl");
`else
        rd(3'd4, 8'hFF, "reg4_absent");
`endif
        rd(3'd5, 8'hFF, "reg5");

        wr(3'd2, 8'h01);
        rd(3'd2, 8'h01, "div_lo_wr");
        repeat (250) @(posedge ram_clk);

        tx_exp.push_back(8'h55);
        wr(3'd0, 8'h55);
        repeat (80) @(posedge ram_clk);
        rd(3'd1, 8'h02, "tx_busy_status");
        repeat (120) @(posedge ram_clk);
        rd(3'd1, 8'h82, "tx_idle_status");
        check("tx_drained_55", tx_exp.size(), 32'd0);

        send(8'hA5, 1'b1, 16);
        repeat (20) @(posedge ram_clk);
        rd(3'd1, 8'h83, "rx_av_status");
        rd(3'd0, 8'hA5, "rx_a5");
        rd(3'd1, 8'h82, "rx_popped_status");
        rd(3'd0, 8'hFF, "rx_empty_read");

        for (int b = 0; b < 17; b++) send(8'(b), 1'b1, 16);
        repeat (20) @(posedge ram_clk);
        rd(3'd1, 8'h87, "ovr_status");
        rd(3'd1, 8'h83, "ovr_cleared");
        for (int i = 0; i < 16; i++) rd(3'd0, 8'(i), "ovr_data");
        rd(3'd1, 8'h82, "ovr_drained");

        send(8'h5A, 1'b0, 12);
        repeat (30) @(posedge ram_clk);
        rd(3'd1, 8'h8A, "frm_status");
        rd(3'd1, 8'h82, "frm_cleared");
        rd(3'd0, 8'hFF, "frm_no_byte");

        @(posedge ram_clk);
        #1;
        bit_out(1'b0, 4);
        ser_rx = 1'b1;
        repeat (30) @(posedge ram_clk);
        rd(3'd1, 8'h82, "glitch_status");
        rd(3'd0, 8'hFF, "glitch_no_byte");

        for (int i = 0; i < 6; i++) begin
            if (i < 5) tx_exp.push_back(8'hC0 + 8'(i));
            wr(3'd0, 8'hC0 + 8'(i));
        end
        rd(3'd1, 8'h10, "txo_status");
        rd(3'd1, 8'h00, "txo_cleared");
        repeat (900) @(posedge ram_clk);
        check("tx_drained_burst", tx_exp.size(), 32'd0);
        rd(3'd1, 8'h82, "burst_idle_status");

`ifdef SCMP_UART_IRQ_EN
        wr(3'd4, 8'h01);
        rd(3'd4, 8'h01, "ctrl_rxie");
        settle();
        check("irq_idle_rxie", {31'd0, irq}, 32'd0);
        send(8'h3C, 1'b1, 16);
        settle();
        check("irq_rx", {31'd0, irq}, 32'd1);
        rd(3'd0, 8'h3C, "irq_rx_data");
        settle();
        check("irq_rx_cleared", {31'd0, irq}, 32'd0);
        wr(3'd4, 8'h02);
        settle();
        check("irq_txidle", {31'd0, irq}, 32'd1);
        wr(3'd4, 8'h00);
        settle();
        check("irq_off", {31'd0, irq}, 32'd0);
`else
        wr(3'd4, 8'h03);
        rd(3'd4, 8'hFF, "reg4_wr_ignored");
        send(8'h3C, 1'b1, 16);
        settle();
        check("irq_tied_low", {31'd0, irq}, 32'd0);
        rd(3'd0, 8'h3C, "rx_3c");
`endif

        tx_mon_en = 1'b0;
        wr(3'd0, 8'hC3);
        repeat (5) @(posedge ram_clk);
        #1;
        check("pre_rst_ser_tx", {31'd0, ser_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ser_tx", {31'd0, ser_tx}, 32'd1);
        check("mid_rst_dout", {24'd0, dout}, 32'h00);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(posedge ram_clk);
        #1;
        rst_n = 1'b1;
        rd(3'd1, 8'h82, "post_rst_status");
        rd(3'd2, 8'hD0, "post_rst_div");
        repeat (20) @(posedge ram_clk);
        check("rd_queue_empty", rd_exp.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
